exec_stage_p: RTL and testbench

EXEC_STAGE_P -- requirements
Module: exec_stage_p

---
 rtl/exec_stage_p_pkg.sv | 36 +++
 rtl/exec_flags.sv | 19 +
 rtl/exec_stage_p.sv | 147 ++++++++++++++
 tb/tb_exec_stage_p.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_stage_p_pkg.sv
// Shared definitions for the execute stage: opcode encodings, flag bit
// positions and default datapath sizes.
package exec_stage_p_pkg;

    localparam int DW_DEF   = 16;
    localparam int IMMW_DEF = 9;
    localparam int TAGW_DEF = 5;

    // Opcode values carried on in_op; anything not listed is a NOP.
    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_ADC = 5'd2,
        OP_ADZ = 5'd3,
        OP_ADL = 5'd4,
        OP_NDU = 5'd5,
        OP_NDC = 5'd6,
        OP_NDZ = 5'd7,
        OP_LHI = 5'd8
    } op_e;

    // Bit positions inside the two-bit flag register.
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // True for the opcodes that go through the adder.
    function automatic logic is_add_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_ADZ) || (op == OP_ADL);
    endfunction

    // True for the opcodes that go through the NAND unit.
    function automatic logic is_nand_op(input logic [4:0] op);
        return (op == OP_NDU) || (op == OP_NDC) || (op == OP_NDZ);
    endfunction

endpackage

// File: rtl/exec_flags.sv
// Architectural carry/zero flag register with a single load enable.
module exec_flags (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ld,
    input  logic [1:0] flags_d,
    output logic [1:0] flags_q
);

    // Flags load only when the stage retires a flag-writing instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flags_q <= 2'b00;
        end else if (ld) begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: rtl/exec_stage_p.sv
// Single-register execute stage: combinational ALU feeding a valid/ready
// output register, with predicated ops gated by the carry/zero flags.
module exec_stage_p
    import exec_stage_p_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IMMW = IMMW_DEF,
    parameter int TAGW = TAGW_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [DW-1:0]   in_opa,
    input  logic [DW-1:0]   in_opb,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_result,
    output logic [DW-1:0]   out_opa,
    output logic [TAGW-1:0] out_tag,
    output logic            out_wr,
    output logic            flag_c,
    output logic            flag_z
);

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_result_q;
    logic [DW-1:0]   out_opa_q;
    logic [TAGW-1:0] out_tag_q;
    logic            out_wr_q;
    logic            accept;

    logic [DW-1:0]   opb_eff;
    logic [DW:0]     sum;
    logic [DW-1:0]   nand_res;
    logic [DW-1:0]   lhi_res;
    logic            exec_en;
    logic [DW-1:0]   alu_res;
    logic            upd_c, upd_z;

    logic [1:0]      flags_q, flags_d;
    logic            flags_ld;

    assign flag_c = flags_q[FLAG_C];
    assign flag_z = flags_q[FLAG_Z];

    // Handshake: the register frees up when empty or being drained; flush
    // vetoes any accept in the same cycle.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready && !flush;
    end

    // ALU datapath and predication; a skipped op produces a zero result and
    // touches no flag.
    always_comb begin
        opb_eff  = (in_op == OP_ADL) ? {in_opb[DW-2:0], 1'b0} : in_opb;
        sum      = {1'b0, in_opa} + {1'b0, opb_eff};
        nand_res = ~(in_opa & in_opb);
        lhi_res  = {in_opb[IMMW-1:0], {(DW-IMMW){1'b0}}};
        exec_en  = 1'b0;
        alu_res  = '0;
        upd_c    = 1'b0;
        upd_z    = 1'b0;
        case (in_op)
            OP_ADD, OP_ADL: exec_en = 1'b1;
            OP_ADC, OP_NDC: exec_en = flag_c;
            OP_ADZ, OP_NDZ: exec_en = flag_z;
            OP_NDU, OP_LHI: exec_en = 1'b1;
            default:        exec_en = 1'b0;
        endcase
        if (exec_en) begin
            if (is_add_op(in_op)) begin
                alu_res = sum[DW-1:0];
                upd_c   = 1'b1;
                upd_z   = 1'b1;
            end else if (is_nand_op(in_op)) begin
                alu_res = nand_res;
                upd_z   = 1'b1;
            end else begin
                alu_res = lhi_res;
            end
        end
    end

    // Next flag values; each flag keeps its old value unless its op class writes it.
    always_comb begin
        flags_d         = flags_q;
        if (upd_c) flags_d[FLAG_C] = sum[DW];
        if (upd_z) flags_d[FLAG_Z] = (alu_res == '0);
        flags_ld        = accept && (upd_c || upd_z);
    end

    exec_flags u_flags (
        .clk     (clk),
        .resetn  (resetn),
        .ld      (flags_ld),
        .flags_d (flags_d),
        .flags_q (flags_q)
    );

    // Output-valid next state: flush wins, then accept, then drain.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output-valid register; reset discards any instruction held in the stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // Output payload registers capture only on accept and hold otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_result_q <= '0;
            out_opa_q    <= '0;
            out_tag_q    <= '0;
            out_wr_q     <= 1'b0;
        end else if (accept) begin
            out_result_q <= alu_res;
            out_opa_q    <= in_opa;
            out_tag_q    <= in_tag;
            out_wr_q     <= exec_en;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opa    = out_opa_q;
    assign out_tag    = out_tag_q;
    assign out_wr     = out_wr_q;

endmodule

// File: tb/tb_exec_stage_p.sv
// Randomised and directed bench for exec_stage_p, checked against a
// cycle-level behavioural model of the stage.
module tb_exec_stage_p;

    localparam int DW   = 16;
    localparam int IMMW = 9;
    localparam int TAGW = 5;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_op = '0;
    logic [DW-1:0]   in_opa = '0;
    logic [DW-1:0]   in_opb = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_result;
    logic [DW-1:0]   out_opa;
    logic [TAGW-1:0] out_tag;
    logic            out_wr;
    logic            flag_c;
    logic            flag_z;

    exec_stage_p #(.DW(DW), .IMMW(IMMW), .TAGW(TAGW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opa    (out_opa),
        .out_tag    (out_tag),
        .out_wr     (out_wr),
        .flag_c     (flag_c),
        .flag_z     (flag_z)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state of the stage as seen from its ports.
    int unsigned m_valid, m_result, m_wr, m_opa, m_tag, m_c, m_z;
    // Expected retirements, in acceptance order.
    int unsigned exp_q[$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_result = 0; m_wr = 0; m_opa = 0; m_tag = 0; m_c = 0; m_z = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string where);
        check_value({where, ".out_valid"},  out_valid,  m_valid);
        check_value({where, ".out_result"}, out_result, m_result);
        check_value({where, ".out_wr"},     out_wr,     m_wr);
        check_value({where, ".out_opa"},    out_opa,    m_opa);
        check_value({where, ".out_tag"},    out_tag,    m_tag);
        check_value({where, ".flag_c"},     flag_c,     m_c);
        check_value({where, ".flag_z"},     flag_z,     m_z);
    endtask

    // One clock: drive inputs just after an edge, predict, then compare just after the next edge.
    task automatic cycle(input logic v, input int unsigned op, input int unsigned a, input int unsigned b,
                         input int unsigned tag, input logic ordy, input logic fl);
        int unsigned rdy, acc, run, res, sum, bb, nc, nz;
        in_valid = v; in_op = op[4:0]; in_opa = a[15:0]; in_opb = b[15:0];
        in_tag = tag[4:0]; out_ready = ordy; flush = fl;
        #1;
        rdy = (m_valid == 0 || ordy) ? 1 : 0;
        check_value("in_ready", in_ready, rdy);
        acc = (v && rdy && !fl) ? 1 : 0;
        // A delivery happens when the register is full and downstream takes it without a flush.
        if (m_valid == 1 && ordy && !fl && exp_q.size() > 0) begin
            check_value("deliver_order", {m_tag[7:0], m_result[15:0]}, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (fl) begin
            m_valid = 0;
            exp_q.delete();
        end else if (acc == 1) m_valid = 1;
        else if (ordy) m_valid = 0;
        if (acc == 1) begin
            run = 0; res = 0; nc = m_c; nz = m_z;
            case (op)
                1, 4: run = 1;
                2, 6: run = m_c;
                3, 7: run = m_z;
                5, 8: run = 1;
                default: run = 0;
            endcase
            if (run == 1) begin
                if (op >= 1 && op <= 4) begin
                    bb  = (op == 4) ? ((b * 2) % 65536) : b;
                    sum = a + bb;
                    res = sum % 65536;
                    nc  = sum / 65536;
                    nz  = (res == 0) ? 1 : 0;
                end else if (op >= 5 && op <= 7) begin
                    res = 65535 - (a & b);
                    nz  = (res == 0) ? 1 : 0;
                end else begin
                    res = (b % 512) * 128;
                end
            end
            m_result = res; m_wr = run; m_opa = a; m_tag = tag; m_c = nc; m_z = nz;
            exp_q.push_back({tag[7:0], res[15:0]});
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // Reset asserted and released between clock edges, checked immediately.
    task automatic mid_reset();
        #2;
        resetn = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        check_value("rst.in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        resetn = 1'b1;
    endtask

    initial begin
        int unsigned op, a, b, sel;
        model_reset();
        #1;
        check_outputs("por");
        check_value("por.in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Carry and zero out of a full-width wrap.
        cycle(1, 1, 16'hFFFF, 16'h0001, 3, 1, 0);
        check_value("add_wrap.result", out_result, 16'h0000);
        check_value("add_wrap.wr", out_wr, 1);
        check_value("add_wrap.c", flag_c, 1);
        check_value("add_wrap.z", flag_z, 1);
        // ADC skipped when carry is clear.
        cycle(1, 1, 16'h0001, 16'h0001, 4, 1, 0);
        cycle(1, 2, 16'h0003, 16'h0004, 5, 1, 0);
        check_value("adc_skip.result", out_result, 0);
        check_value("adc_skip.wr", out_wr, 0);
        check_value("adc_skip.c", flag_c, 0);
        // ADC executes when carry is set, back to back with the producer.
        cycle(1, 1, 16'hFFFF, 16'h0001, 6, 1, 0);
        cycle(1, 2, 16'h0003, 16'h0004, 7, 1, 0);
        check_value("adc_run.result", out_result, 16'h0007);
        check_value("adc_run.wr", out_wr, 1);
        // LHI leaves flags alone; NDU clears Z.
        cycle(1, 8, 16'h1234, 16'h01FF, 8, 1, 0);
        check_value("lhi.result", out_result, 16'hFF80);
        check_value("lhi.c", flag_c, 0);
        cycle(1, 5, 16'hFFFF, 16'h00FF, 9, 1, 0);
        check_value("ndu.result", out_result, 16'hFF00);
        check_value("ndu.z", flag_z, 0);
        // Backpressure for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 16'h0010, 16'h0020, 10, 0, 0);
            check_value("stall.result", out_result, 16'hFF00);
            check_value("stall.in_ready", in_ready, 0);
        end
        cycle(1, 1, 16'h0010, 16'h0020, 10, 1, 0);
        check_value("release.result", out_result, 16'h0030);
        check_value("release.tag", out_tag, 10);
        // Flush with a full register and a flag-writing instruction incoming.
        cycle(1, 1, 16'hFFFF, 16'h0001, 11, 0, 1);
        check_value("flush.valid", out_valid, 0);
        check_value("flush.c", flag_c, 0);
        // Load something, then reset in the middle of the stream.
        cycle(1, 1, 16'hFFFF, 16'h0002, 12, 0, 0);
        mid_reset();
        cycle(1, 2, 16'h0001, 16'h0001, 13, 1, 0);
        check_value("post_rst.adc_wr", out_wr, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            op  = $urandom_range(0, 10);
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? 16'hFFFF : (sel == 1) ? 0 : $urandom_range(0, 65535);
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 16'h0001 : (sel == 1) ? 0 : $urandom_range(0, 65535);
            cycle($urandom_range(0, 4) != 0, op, a, b, $urandom_range(0, 31),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            if (i == 300) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
